serial_adder_fsm: RTL and testbench
===================================

Name: serial_adder_fsm

Overview:
- Bit-serial adder built around one instance of the team's 1-bit full adder `FA` (ports a, b, cin, cout, sum).
- Loads two WIDTH-bit operands and a carry-in on a start pulse, then feeds one bit pair per clock into `FA`, LSB first.
- Registers the FA carry-out back into cin each cycle and shifts FA sum into a result register.
- Signals completion with a one-cycle done pulse; final sum and carry-out are held until the next start.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured on the accepted start edge
- b_in  input  WIDTH  operand B; captured on the accepted start edge
- cin_in  input  1  initial carry; captured on the accepted start edge
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; result valid
- sum_out  output  WIDTH  registered sum
- cout_out  output  1  registered final carry-out
- ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset: one clock with rst=1 forces:
  - state IDLE, busy=0, done=0, sum_out=0, cout_out=0, ovf=0;
  - internal shift registers, carry flop and bit counter all cleared.
- rst has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 loads shift regs A<=a_in, B<=b_in, carry<=cin_in and count<=0, then moves to RUN.
  - sum_out and cout_out keep their previous values until the next DONE.
- RUN (busy=1):
  - FA inputs: a=A[0], b=B[0], cin=carry.
  - Each edge: A and B shift right by one; FA sum shifts into the result register MSB (result <= {sum, result[WIDTH-1:1]}); carry<=FA cout; count increments.
  - Edges E1..E(WIDTH) process bits 0..WIDTH-1.
  - After edge E(WIDTH) (count reaches WIDTH-1 on entry to that edge), the state moves to DONE.
- DONE:
  - sum_out = result register, cout_out = carry, done=1, busy=0.
  - The next edge returns the state to IDLE and drops done to 0.
- Latency: done is high in the cycle following edge E(WIDTH), i.e. WIDTH+1 clocks after the accepted start edge.
- Throughput: one operation per WIDTH+2 cycles (the start can be accepted on the edge where DONE exits to IDLE only if the state is already IDLE, so start must be re-sampled in IDLE).
- start while RUN or DONE: ignored, with no effect on operands or result; it is not queued.
- a_in, b_in, cin_in changing after the start edge: no effect.
- Reset mid-RUN: the operation is aborted, the state returns to IDLE, outputs are cleared, and no done pulse is produced.
- Arithmetic: {cout_out, sum_out} = a_in + b_in + cin_in, unsigned, modulo 2^(WIDTH+1). No saturation.
- Bit counter width: minimal width that holds WIDTH-1 (at least 1 bit).
- WIDTH=1: exactly one RUN cycle; the result equals a single FA evaluation.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - An extra flop captures the carry into the MSB, i.e. the cin applied during the last RUN cycle.
  - In DONE, ovf = that captured carry XOR the final carry-out (two's-complement signed overflow).
  - ovf is held with sum_out until the next DONE; it is cleared by reset.
- Not defined:
  - ovf is tied to constant 0 and no extra flop is synthesised.
  - The ovf port is present in both builds.

Test Plan:
- WIDTH=8, rst high for 2 cycles then low -> busy=0, done=0, sum_out=0x00, cout_out=0, ovf=0.
- WIDTH=8, a_in=0x5A, b_in=0x3C, cin_in=0, start pulse -> done exactly 9 cycles after the start edge with sum_out=0x96, cout_out=0; ovf=1 if SERIAL_ADD_OVF_EN is defined, else 0.
- WIDTH=8, a_in=0xFF, b_in=0x01, cin_in=0 -> sum_out=0x00, cout_out=1, ovf=0. Then a_in=0xFF, b_in=0x00, cin_in=1 -> sum_out=0x00, cout_out=1.
- WIDTH=8, start 0x10+0x20, then pulse start again with 0xFF+0xFF at RUN cycle 3 -> second start ignored; result 0x30, cout_out=0, exactly one done pulse.
- WIDTH=8, start 0x80+0x80, assert rst for 1 cycle at RUN cycle 4 -> state IDLE, busy=0, sum_out=0x00, no done pulse; a fresh 0x01+0x02 afterwards -> 0x03.
- WIDTH=1, loop i=0..7 with {a_in, b_in, cin_in}=i, 5-cycle spacing -> {cout_out, sum_out} matches the full-adder truth table (00,01,01,10,01,10,10,11); done latency 2 cycles each.

Source files
------------

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one FA evaluation per clock, LSB first, with done pulse.
// Optional signed-overflow flag enabled by defining SERIAL_ADD_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// RUN   | one bit pair per clock through the full adder
// DONE  | one-cycle done pulse; result valid

module FA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic sum
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             load;
  // acc starts as operand A; sum bits enter at the top as A bits leave the bottom
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_sum, fa_cout;

  FA u_fa (
    .a    (acc[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .cout (fa_cout),
    .sum  (fa_sum)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_nxt = fa_sum;
    end else begin : g_acc_wn
      assign acc_nxt = {fa_sum, acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else if (load) begin
      acc   <= a_in;
      b_sr  <= b_in;
      carry <= cin_in;
      cnt   <= '0;
    end else if (busy) begin
      acc   <= acc_nxt;
      b_sr  <= b_sr >> 1;
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        sum_out  <= acc_nxt;
        cout_out <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // carry still holds the carry into the MSB during the last RUN cycle
  always_ff @(posedge clk) begin
    if (rst)                    ovf <= 1'b0;
    else if (busy && last_bit)  ovf <= carry ^ fa_cout;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm: WIDTH=8 vector table plus corner sequences,
// and a WIDTH=1 full-adder truth-table sweep.
module tb_serial_adder_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;
  int dp8 = 0;
  int dp1 = 0;

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8), .ovf(ovf8)
  );

  serial_adder_fsm #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin_in(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1), .ovf(ovf1)
  );

  always @(negedge clk) begin
    if (done8) dp8++;
    if (done1) dp1++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // start edge counts as cycle 1; returns cycles until done is seen (bounded)
  task automatic wait_done8(output int lat);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c;
    wait_done8(lat);
  endtask

  function automatic logic exp_ovf(input logic v);
`ifdef SERIAL_ADD_OVF_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    int lat;
    int dp_before;
    logic [1:0] fa_tt[8];

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};

    fa_tt[0] = 2'b00; fa_tt[1] = 2'b01; fa_tt[2] = 2'b01; fa_tt[3] = 2'b10;
    fa_tt[4] = 2'b01; fa_tt[5] = 2'b10; fa_tt[6] = 2'b10; fa_tt[7] = 2'b11;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_w1", {busy1, done1, sum1, cout1, ovf1}, 0);

    for (int i = 0; i < 8; i++) begin
      dp_before = dp8;
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      chk($sformatf("v%0d_lat", i), lat, 9);
      chk($sformatf("v%0d_sum", i), sum8, vecs[i].sum);
      chk($sformatf("v%0d_cout", i), cout8, vecs[i].cout);
      chk($sformatf("v%0d_ovf", i), ovf8, exp_ovf(vecs[i].v));
      chk($sformatf("v%0d_busy", i), busy8, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_drop", i), done8, 0);
      chk($sformatf("v%0d_hold", i), {cout8, sum8}, {vecs[i].cout, vecs[i].sum});
      chk($sformatf("v%0d_pulses", i), dp8 - dp_before, 1);
    end

    // start pulse during RUN is ignored
    dp_before = dp8;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ign_busy", busy8, 1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", lat, 9);
    chk("ign_sum", sum8, 8'h30);
    chk("ign_cout", cout8, 0);
    repeat (12) @(posedge clk); #1;
    chk("ign_pulses", dp8 - dp_before, 1);
    chk("ign_idle", busy8, 0);

    // reset mid-RUN aborts with no done pulse
    dp_before = dp8;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 0);
    repeat (12) @(posedge clk); #1;
    chk("abort_no_done", dp8 - dp_before, 0);
    chk("abort_idle", busy8, 0);
    op8(8'h01, 8'h02, 1'b0, lat);
    chk("post_abort_lat", lat, 9);
    chk("post_abort_sum", {cout8, sum8}, 9'h003);

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      dp_before = dp1;
      @(negedge clk);
      a1 = iv[2]; b1 = iv[1]; cin1 = iv[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("w1_%0d_lat", i), lat, 2);
      chk($sformatf("w1_%0d_res", i), {cout1, sum1}, fa_tt[i]);
      repeat (3) @(posedge clk); #1;
      chk($sformatf("w1_%0d_pulses", i), dp1 - dp_before, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
